// File: rtl/timer_sched.sv
// ----------------------------------------------------------------------------
// timer_sched
//   Round-robin scheduler that shares one W-bit down-counter among NCH delay
//   requesters. A granted channel has its delay latched. When that delay
//   expires the channel gets a one-cycle done pulse. Only one delay runs at a
//   time. The other requesters wait in arbitration.
//
//   Optional feature: define TIMER_SCHED_BUS_EN to add a CPU register port
//   that gives counter/status readback and an abort command.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous reset, active low
//   req        in   NCH    per-channel delay request (level, held until gnt)
//   req_delay  in   NCH*W  delay per channel, channel i in [i*W +: W]
//   gnt        out  NCH    one-cycle pulse: request accepted, delay latched
//   done       out  NCH    one-cycle pulse: delay of that channel expired
//   busy       out  1      counter in use
//   cur_ch     out  CW     channel being served (holds its value when idle)
//   dbr        out  8      [BUS_EN] registered read data, 0 when not reading
//   dbw        in   8      [BUS_EN] write data
//   addr       in   2      [BUS_EN] register address
//   cs         in   1      [BUS_EN] chip select
//   we         in   1      [BUS_EN] write enable
// ----------------------------------------------------------------------------
module timer_sched #(
    parameter int NCH = 4,
    parameter int W   = 16,
    parameter int CW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic [NCH*W-1:0] req_delay,
    output logic [NCH-1:0]   gnt,
    output logic [NCH-1:0]   done,
    output logic             busy,
    output logic [CW-1:0]    cur_ch
`ifdef TIMER_SCHED_BUS_EN
    ,
    output logic [7:0]       dbr,
    input  logic [7:0]       dbw,
    input  logic [1:0]       addr,
    input  logic             cs,
    input  logic             we
`endif
);

    typedef enum logic {S_IDLE, S_COUNT} state_t;

    localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [W-1:0]     r_counter;
    logic [CW-1:0]    r_cur_ch;
    logic [CW-1:0]    r_rr_last;
    logic [NCH-1:0]   r_gnt;
    logic [NCH-1:0]   r_done;

    logic             w_found;
    logic [CW-1:0]    w_pick;
    logic             w_abort;

    // Round-robin pick: first set request starting just after the last grant.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NCH; k++) begin
            logic [CW-1:0] idx;
            idx = CW'((int'(r_rr_last) + k) % NCH);
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_pick  = idx;
            end
        end
    end

`ifdef TIMER_SCHED_BUS_EN
    localparam int EW = (W > 16) ? W : 16;
    logic [EW-1:0] w_cnt_ext;
    assign w_cnt_ext = EW'(r_counter);
    assign w_abort   = cs && we && (addr == 2'd2) && dbw[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbr <= 8'h00;
        end else if (cs && !we) begin
            case (addr)
                2'd0:    dbr <= w_cnt_ext[7:0];
                2'd1:    dbr <= w_cnt_ext[15:8];
                2'd2:    dbr <= {(r_state == S_COUNT), 4'b0000, 3'(r_cur_ch)};
                default: dbr <= 8'h00;
            endcase
        end else begin
            dbr <= 8'h00;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update together from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_counter <= '0;
            r_cur_ch  <= '0;
            r_rr_last <= CW'(NCH - 1);
            r_gnt     <= '0;
            r_done    <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_counter <= req_delay[w_pick*W +: W];
                        r_cur_ch  <= w_pick;
                        r_rr_last <= w_pick;
                        r_gnt     <= ONE_HOT0 << w_pick;
                        r_state   <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    // An abort takes priority over expiry and suppresses done.
                    if (w_abort) begin
                        r_counter <= '0;
                        r_state   <= S_IDLE;
                    end else if (r_counter != '0) begin
                        r_counter <= r_counter - 1'b1;
                    end else begin
                        r_done  <= ONE_HOT0 << r_cur_ch;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign busy   = (r_state == S_COUNT);
    assign cur_ch = r_cur_ch;

endmodule

// File: tb/tb_timer_sched.sv
// ----------------------------------------------------------------------------
// tb_timer_sched
//   Directed testbench for timer_sched (NCH=4, W=16). Expected values are
//   computed by hand from the scheduling rules: latency D+1 from gnt to done,
//   and round-robin order starting after the last granted channel.
// ----------------------------------------------------------------------------
module tb_timer_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_delay;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  cur_ch;
`ifdef TIMER_SCHED_BUS_EN
    logic [7:0]  dbr;
    logic [7:0]  dbw;
    logic [1:0]  addr;
    logic        cs;
    logic        we;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    timer_sched #(.NCH(4), .W(16), .CW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_delay (req_delay),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .cur_ch    (cur_ch)
`ifdef TIMER_SCHED_BUS_EN
        ,
        .dbr       (dbr),
        .dbw       (dbw),
        .addr      (addr),
        .cs        (cs),
        .we        (we)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delay(input int ch, input logic [15:0] val);
        req_delay[ch*16 +: 16] = val;
    endtask

    // Raise the request mask, expect a grant of exp_ch on the next edge, then
    // wait (bounded) for done and check its latency and the busy duration.
    task automatic serve(input logic [3:0] mask, input int exp_ch, input int exp_lat,
                         input bit hold, input string tag);
        int n;
        int nbusy;
        bit seen;
        req = mask;
        step();
        check({tag, "_gnt"},  32'(gnt),    32'(4'b0001 << exp_ch));
        check({tag, "_cur"},  32'(cur_ch), 32'(exp_ch));
        check({tag, "_busy"}, 32'(busy),   32'd1);
        if (!hold) req = 4'b0000;
        n = 0;
        nbusy = 1;
        seen = 1'b0;
        while (!seen && n < 200) begin
            step();
            n++;
            if (done != 4'b0000) seen = 1'b1;
            else if (busy) nbusy++;
        end
        check({tag, "_lat"},       32'(n),     32'(exp_lat));
        check({tag, "_done"},      32'(done),  32'(4'b0001 << exp_ch));
        check({tag, "_gnt_at_dn"}, 32'(gnt),   32'd0);
        check({tag, "_busy_dn"},   32'(busy),  32'd0);
        check({tag, "_nbusy"},     32'(nbusy), 32'(exp_lat));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        step();
        rst = 1'b1;
    endtask

    initial begin
        int seen_done;
        rst = 1'b0;
        req = 4'b0000;
        req_delay = '0;
`ifdef TIMER_SCHED_BUS_EN
        dbw = 8'h00;
        addr = 2'd0;
        cs = 1'b0;
        we = 1'b0;
`endif
        step();
        step();
        check("rst_gnt",  32'(gnt),    32'd0);
        check("rst_done", 32'(done),   32'd0);
        check("rst_busy", 32'(busy),   32'd0);
        check("rst_cur",  32'(cur_ch), 32'd0);
        rst = 1'b1;
        step();
        check("idle_no_req_busy", 32'(busy), 32'd0);

        // Single channel, delay 5: done 6 cycles after gnt, busy 6 cycles.
        set_delay(0, 16'd5);
        serve(4'b0001, 0, 6, 0, "t1");

        // Delay 0: done on the cycle right after gnt.
        set_delay(0, 16'd0);
        serve(4'b0001, 0, 1, 0, "t2");

        // All channels held high, delay 1 each: order 0,1,2,3,0 after reset.
        do_reset();
        for (int i = 0; i < 4; i++) set_delay(i, 16'd1);
        serve(4'b1111, 0, 2, 1, "t3a");
        serve(4'b1111, 1, 2, 1, "t3b");
        serve(4'b1111, 2, 2, 1, "t3c");
        serve(4'b1111, 3, 2, 1, "t3d");
        serve(4'b1111, 0, 2, 0, "t3e");

        // Serve ch2, then 0101 wraps past 3 to ch0 first, then ch2.
        set_delay(0, 16'd3);
        set_delay(2, 16'd0);
        serve(4'b0100, 2, 1, 0, "t4a");
        serve(4'b0101, 0, 4, 1, "t4b");
        serve(4'b0101, 2, 1, 0, "t4c");

        // Reset three cycles into a delay of 10 discards the delay.
        set_delay(1, 16'd10);
        req = 4'b0010;
        step();
        check("t5_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        step();
        step();
        step();
        check("t5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_rst_gnt",  32'(gnt),    32'd0);
        check("t5_rst_done", 32'(done),   32'd0);
        check("t5_rst_busy", 32'(busy),   32'd0);
        check("t5_rst_cur",  32'(cur_ch), 32'd0);
        #1;
        rst = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done != 4'b0000) seen_done++;
        end
        check("t5_no_done", 32'(seen_done), 32'd0);
        check("t5_idle",    32'(busy),      32'd0);
        // Round-robin pointer returns to NCH-1: all requests -> ch0 wins.
        set_delay(0, 16'd2);
        serve(4'b1111, 0, 3, 0, "t5_rr");

`ifdef TIMER_SCHED_BUS_EN
        // Readback of the latched counter, then abort.
        set_delay(0, 16'h1234);
        req = 4'b0001;
        step();
        check("t6_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        check("t6_dbr_idle", 32'(dbr), 32'h00);
        cs = 1'b1;
        we = 1'b0;
        addr = 2'd0;
        step();
        check("t6_rd0", 32'(dbr), 32'h34);
        addr = 2'd1;
        step();
        check("t6_rd1", 32'(dbr), 32'h12);
        addr = 2'd2;
        step();
        check("t6_rd2", 32'(dbr), 32'h80);
        we = 1'b1;
        dbw = 8'h01;
        step();
        cs = 1'b0;
        we = 1'b0;
        dbw = 8'h00;
        check("t6_abort_busy", 32'(busy), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done != 4'b0000) seen_done++;
        end
        check("t6_abort_no_done", 32'(seen_done), 32'd0);

        // Abort on the same edge as counter==0: abort wins.
        set_delay(0, 16'd1);
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        cs = 1'b1;
        we = 1'b1;
        addr = 2'd2;
        dbw = 8'h01;
        step();
        cs = 1'b0;
        we = 1'b0;
        dbw = 8'h00;
        check("t6_tie_done", 32'(done), 32'd0);
        check("t6_tie_busy", 32'(busy), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done != 4'b0000) seen_done++;
        end
        check("t6_tie_no_done", 32'(seen_done), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
